// File: rtl/branch_predictor_resolver_pkg.sv
// branch_predictor_resolver_pkg
// Shared definitions for the branch predictor resolver: condition-code
// constants, branch-word field positions, FSM state encoding, the counter
// reset value and small helper functions for condition evaluation and
// saturating counter update.
// Optional feature macro used by the files of this slice: BRANCH_PREDICTOR_STATS_EN.
package branch_predictor_resolver_pkg;

  // Condition codes carried in the branch word
  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_CY     = 3'b001;
  localparam logic [2:0] COND_NCY    = 3'b010;
  localparam logic [2:0] COND_WZ     = 3'b011;
  localparam logic [2:0] COND_WNZ    = 3'b100;
  localparam logic [2:0] COND_WNEG   = 3'b101;
  localparam logic [2:0] COND_WPOS   = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  // Branch-word field positions
  localparam int BR_VALID_BIT = 21;
  localparam int BR_COND_HI   = 20;
  localparam int BR_COND_LO   = 18;
  localparam int BR_TGT_HI    = 10;
  localparam int BR_TGT_LO    = 0;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PREDICT   = 2'd1;
  localparam logic [1:0] ST_WAIT_EXEC = 2'd2;

  // Counters come out of reset weakly not taken
  localparam logic [1:0] CTR_RESET = 2'b01;

  // Actual branch outcome for a condition code given W and CY
  function automatic logic cond_taken(input logic [2:0] code,
                                      input logic [15:0] w,
                                      input logic cy);
    logic taken;
    case (code)
      COND_ALWAYS: taken = 1'b1;
      COND_CY:     taken = cy;
      COND_NCY:    taken = ~cy;
      COND_WZ:     taken = (w == 16'h0000);
      COND_WNZ:    taken = (w != 16'h0000);
      COND_WNEG:   taken = w[15];
      COND_WPOS:   taken = ~w[15];
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Unconditional codes neither consult nor train the counter table
  function automatic logic is_conditional(input logic [2:0] code);
    return (code != COND_ALWAYS) && (code != COND_NEVER);
  endfunction

  // 2-bit saturating counter step
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) nxt = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) nxt = ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_resolver_if.sv
// branch_predictor_resolver_if
// Bundles the latched branch inputs coming from the predictor input latch and
// the prediction/resolution outputs going to fetch.
//   slave  modport: used by branch_predictor_resolver (latched_* in, results out)
//   master modport: used by the producer/consumer side (latched_* out, results in)
// With BRANCH_PREDICTOR_STATS_EN defined, stat_resolved/stat_mispredicts are added.
interface branch_predictor_resolver_if;
  logic [21:0] latched_branch;
  logic [10:0] latched_branch_addr;
  logic [15:0] latched_W;
  logic        latched_CY;
  logic        latched_exec_done;
  logic        busy;
  logic        predict_valid;
  logic        predict_taken;
  logic [10:0] predict_addr;
  logic        resolve_valid;
  logic        mispredict;
  logic [10:0] redirect_addr;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [15:0] stat_resolved;
  logic [15:0] stat_mispredicts;
`endif

  modport slave (
`ifdef BRANCH_PREDICTOR_STATS_EN
    output stat_resolved, output stat_mispredicts,
`endif
    input  latched_branch, input latched_branch_addr, input latched_W,
    input  latched_CY, input latched_exec_done,
    output busy, output predict_valid, output predict_taken, output predict_addr,
    output resolve_valid, output mispredict, output redirect_addr
  );

  modport master (
`ifdef BRANCH_PREDICTOR_STATS_EN
    input  stat_resolved, input stat_mispredicts,
`endif
    output latched_branch, output latched_branch_addr, output latched_W,
    output latched_CY, output latched_exec_done,
    input  busy, input predict_valid, input predict_taken, input predict_addr,
    input  resolve_valid, input mispredict, input redirect_addr
  );
endinterface

// File: rtl/branch_predictor_resolver_counter_table.sv
// bp_counter_table
// 2^IDX_W entries of 2-bit saturating counters.
//   clock, reset : clock and asynchronous active-high reset (entries -> 01)
//   rd_idx/rd_data : combinational lookup port
//   wr_en/wr_idx/wr_taken : synchronous saturating increment/decrement
module bp_counter_table
  import branch_predictor_resolver_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] ctr_d [DEPTH];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) ctr_d[wr_idx] = ctr_next(ctr_q[wr_idx], wr_taken);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RESET;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign rd_data = ctr_q[rd_idx];
endmodule

// File: rtl/branch_predictor_resolver.sv
// branch_predictor_resolver
// Accepts a latched branch, predicts its direction from a table of 2-bit
// counters, waits for execution to finish, then resolves the real outcome,
// trains the table and reports mispredict plus the correct next PC.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : latched branch inputs in, busy/predict_*/resolve_* out
// Optional: BRANCH_PREDICTOR_STATS_EN adds saturating stat_resolved and
// stat_mispredicts counters on the interface.
module branch_predictor_resolver
  import branch_predictor_resolver_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic                        clock,
  input  logic                        reset,
  branch_predictor_resolver_if.slave  bus
);
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       code_q, code_d;
  logic [10:0]      target_q, target_d;
  logic [10:0]      fall_q, fall_d;
  logic             predict_valid_q, predict_valid_d;
  logic             predict_taken_q, predict_taken_d;
  logic [10:0]      predict_addr_q, predict_addr_d;
  logic             resolve_valid_q, resolve_valid_d;
  logic             mispredict_q, mispredict_d;
  logic [10:0]      redirect_addr_q, redirect_addr_d;

  logic [1:0]       rd_data;
  logic             wr_en;
  logic             actual_taken;
  logic             lookup_taken;
  logic [2:0]       in_code;
  logic [10:0]      in_target;
  logic [10:0]      in_fall;
  logic             unused_branch_bits;

  assign in_code   = bus.latched_branch[BR_COND_HI:BR_COND_LO];
  assign in_target = bus.latched_branch[BR_TGT_HI:BR_TGT_LO];
  assign in_fall   = bus.latched_branch_addr + 11'd1;
  assign unused_branch_bits = ^bus.latched_branch[17:11];

  // Outcome is always evaluated on the W/CY presented in the exec_done cycle
  assign actual_taken = cond_taken(code_q, bus.latched_W, bus.latched_CY);

  bp_counter_table #(.IDX_W(IDX_W)) u_table (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (bus.latched_branch_addr[IDX_W-1:0]),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (idx_q),
    .wr_taken (actual_taken)
  );

  always_comb begin
    case (in_code)
      COND_ALWAYS: lookup_taken = 1'b1;
      COND_NEVER:  lookup_taken = 1'b0;
      default:     lookup_taken = rd_data[1];
    endcase
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    code_d          = code_q;
    target_d        = target_q;
    fall_d          = fall_q;
    predict_valid_d = 1'b0;
    predict_taken_d = predict_taken_q;
    predict_addr_d  = predict_addr_q;
    resolve_valid_d = 1'b0;
    mispredict_d    = mispredict_q;
    redirect_addr_d = redirect_addr_q;
    wr_en           = 1'b0;
    case (state_q)
      // exec_done is deliberately ignored here, even alongside a new branch
      ST_IDLE: begin
        if (bus.latched_branch[BR_VALID_BIT]) begin
          idx_d           = bus.latched_branch_addr[IDX_W-1:0];
          code_d          = in_code;
          target_d        = in_target;
          fall_d          = in_fall;
          predict_valid_d = 1'b1;
          predict_taken_d = lookup_taken;
          predict_addr_d  = lookup_taken ? in_target : in_fall;
          state_d         = ST_PREDICT;
        end
      end
      ST_PREDICT, ST_WAIT_EXEC: begin
        if (bus.latched_exec_done) begin
          resolve_valid_d = 1'b1;
          mispredict_d    = actual_taken != predict_taken_q;
          redirect_addr_d = actual_taken ? target_q : fall_q;
          wr_en           = is_conditional(code_q);
          state_d         = ST_IDLE;
        end else begin
          state_d = ST_WAIT_EXEC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      code_q          <= '0;
      target_q        <= '0;
      fall_q          <= '0;
      predict_valid_q <= 1'b0;
      predict_taken_q <= 1'b0;
      predict_addr_q  <= '0;
      resolve_valid_q <= 1'b0;
      mispredict_q    <= 1'b0;
      redirect_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      code_q          <= code_d;
      target_q        <= target_d;
      fall_q          <= fall_d;
      predict_valid_q <= predict_valid_d;
      predict_taken_q <= predict_taken_d;
      predict_addr_q  <= predict_addr_d;
      resolve_valid_q <= resolve_valid_d;
      mispredict_q    <= mispredict_d;
      redirect_addr_q <= redirect_addr_d;
    end
  end

  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.predict_valid = predict_valid_q;
  assign bus.predict_taken = predict_taken_q;
  assign bus.predict_addr  = predict_addr_q;
  assign bus.resolve_valid = resolve_valid_q;
  assign bus.mispredict    = mispredict_q;
  assign bus.redirect_addr = redirect_addr_q;

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [15:0] stat_resolved_q, stat_resolved_d;
  logic [15:0] stat_mispredicts_q, stat_mispredicts_d;

  // Both counters step on the resolve edge and stick at all-ones
  always_comb begin
    stat_resolved_d    = stat_resolved_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (resolve_valid_d) begin
      if (stat_resolved_q != 16'hFFFF) stat_resolved_d = stat_resolved_q + 16'd1;
      if (mispredict_d && stat_mispredicts_q != 16'hFFFF)
        stat_mispredicts_d = stat_mispredicts_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_resolved_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_resolved_q    <= stat_resolved_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign bus.stat_resolved    = stat_resolved_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
`endif
endmodule
